// File: rtl/rle_encoder.sv
// Run-length encoder: collapses a valid/ready word stream into (data, count)
// pairs and writes them through the pair memory's write port.
module rle_encoder #(
   parameter int DW0   = 32,
   parameter int DW1   = 4,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           start,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW0-1:0] in_data,
   input  logic           in_last,
   output logic           CS,
   output logic           wr_en,
   output logic [AW-1:0]  wr_adr,
   output logic [DW0-1:0] wr_din,
   output logic [DW1-1:0] wr_cin,
   output logic           done,
   output logic [AW:0]    pair_cnt,
   output logic           overflow
);

   localparam logic [DW1-1:0] MAXRUN  = '1;
   localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, EMPTY, RUN, FLUSH} state_t;

   typedef struct packed {
      logic [DW0-1:0] d;
      logic [DW1-1:0] cnt;
   } run_t;

   state_t      state;
   run_t        cur;
   logic [AW:0] ptr;

   logic xfer, same, issue, ovf_hit;

   assign in_ready = (state == EMPTY) || (state == RUN);
   assign xfer     = in_valid & in_ready;
   assign same     = (in_data == cur.d) && (cur.cnt < MAXRUN);

   // A held run is emitted when a transfer breaks it (or saturates it) and
   // unconditionally on the flush cycle.
   always_comb begin
      issue = 1'b0;
      case (state)
         RUN:     issue = xfer && !same;
         FLUSH:   issue = 1'b1;
         default: issue = 1'b0;
      endcase
   end

   assign ovf_hit  = issue && (ptr == DEPTH_W);
   assign pair_cnt = ptr;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         cur      <= '0;
         ptr      <= '0;
         CS       <= 1'b0;
         wr_en    <= 1'b0;
         wr_adr   <= '0;
         wr_din   <= '0;
         wr_cin   <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         CS    <= 1'b0;
         wr_en <= 1'b0;
         done  <= 1'b0;

         if (issue && !ovf_hit) begin
            CS     <= 1'b1;
            wr_en  <= 1'b1;
            wr_adr <= ptr[AW-1:0];
            wr_din <= cur.d;
            wr_cin <= cur.cnt;
            ptr    <= ptr + (AW+1)'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  ptr      <= '0;
                  overflow <= 1'b0;
                  state    <= EMPTY;
               end
            end
            EMPTY: begin
               if (xfer) begin
                  cur.d   <= in_data;
                  cur.cnt <= DW1'(1);
                  state   <= in_last ? FLUSH : RUN;
               end
            end
            RUN: begin
               if (xfer) begin
                  if (ovf_hit) begin
                     // Pair memory full: abandon the rest of the frame.
                     overflow <= 1'b1;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     if (same) begin
                        cur.cnt <= cur.cnt + DW1'(1);
                     end else begin
                        cur.d   <= in_data;
                        cur.cnt <= DW1'(1);
                     end
                     if (in_last) state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (ovf_hit) overflow <= 1'b1;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder with a small pair memory (DEPTH=4) so the
// overflow path is reachable; every write is captured by a negedge monitor.
module tb_rle_encoder;

   localparam int DW0 = 32, DW1 = 4, DEPTH = 4, AW = 2;

   logic           CLK = 1'b0;
   logic           RST = 1'b0;
   logic           start = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [DW0-1:0] in_data = '0;
   logic           in_last = 1'b0;
   logic           CS, wr_en, done, overflow;
   logic [AW-1:0]  wr_adr;
   logic [DW0-1:0] wr_din;
   logic [DW1-1:0] wr_cin;
   logic [AW:0]    pair_cnt;

   rle_encoder #(.DW0(DW0), .DW1(DW1), .DEPTH(DEPTH), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .CS(CS), .wr_en(wr_en), .wr_adr(wr_adr), .wr_din(wr_din),
      .wr_cin(wr_cin), .done(done), .pair_cnt(pair_cnt), .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [AW-1:0]  adr;
      logic [DW0-1:0] d;
      logic [DW1-1:0] c;
      logic           dn;
      int             cyc;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  done_cnt = 0;
   int  cs_bad = 0;
   int  total = 0;
   int  bad = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (wr_en) wq.push_back('{wr_adr, wr_din, wr_cin, done, cyc});
      if (done) done_cnt = done_cnt + 1;
      if (CS !== wr_en) cs_bad = cs_bad + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   logic [DW0-1:0] vec[32];
   int qb, db, lc;

   task automatic send(input logic [DW0-1:0] d, input bit last, output int ecyc);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
      @(negedge CLK);
      ecyc     = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic start_frame();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_cnt == db && n < 60) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 60) chk("done_timeout", 64'd0, 64'd1);
      repeat (2) @(negedge CLK);
   endtask

   task automatic run_frame(input int nw, input int gap, output int last_cyc);
      int c;
      db = done_cnt;
      qb = wq.size();
      start_frame();
      for (int i = 0; i < nw; i++) begin
         send(vec[i], (i == nw-1), c);
         if (i != nw-1) repeat (gap) @(negedge CLK);
      end
      last_cyc = c;
      wait_done();
   endtask

   task automatic chk_pair(input string tag, input int k, input logic [AW-1:0] adr,
                           input logic [DW0-1:0] d, input logic [DW1-1:0] c);
      if (qb + k < wq.size()) begin
         chk({tag, "_adr"}, 64'(wq[qb+k].adr), 64'(adr));
         chk({tag, "_din"}, 64'(wq[qb+k].d), 64'(d));
         chk({tag, "_cin"}, 64'(wq[qb+k].c), 64'(c));
      end else begin
         chk({tag, "_missing"}, 64'(wq.size() - qb), 64'(k + 1));
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"},  64'(in_ready), 64'd0);
      chk({tag, "_cs"},     64'(CS),       64'd0);
      chk({tag, "_wren"},   64'(wr_en),    64'd0);
      chk({tag, "_adr"},    64'(wr_adr),   64'd0);
      chk({tag, "_din"},    64'(wr_din),   64'd0);
      chk({tag, "_cin"},    64'(wr_cin),   64'd0);
      chk({tag, "_done"},   64'(done),     64'd0);
      chk({tag, "_pcnt"},   64'(pair_cnt), 64'd0);
      chk({tag, "_ovf"},    64'(overflow), 64'd0);
   endtask

   localparam logic [DW0-1:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002;

   initial begin
      int c;
      repeat (3) @(negedge CLK);
      chk_idle_outputs("reset");
      RST = 1'b1;
      @(negedge CLK);

      // A,A,A,B(last), back to back
      vec[0] = A; vec[1] = A; vec[2] = A; vec[3] = B;
      run_frame(4, 0, lc);
      chk("s1_nwr", 64'(wq.size() - qb), 64'd2);
      chk_pair("s1_p0", 0, 2'd0, A, 4'd3);
      chk_pair("s1_p1", 1, 2'd1, B, 4'd1);
      if (wq.size() >= qb + 2) begin
         chk("s1_p0_cyc",  64'(wq[qb].cyc),   64'(lc));
         chk("s1_p1_cyc",  64'(wq[qb+1].cyc), 64'(lc + 1));
         chk("s1_p0_done", 64'(wq[qb].dn),    64'd0);
         chk("s1_p1_done", 64'(wq[qb+1].dn),  64'd1);
      end
      chk("s1_ndone", 64'(done_cnt - db), 64'd1);
      chk("s1_pcnt",  64'(pair_cnt), 64'd2);
      chk("s1_ovf",   64'(overflow), 64'd0);

      // 20 equal words: saturates at 15 and restarts at 1
      for (int i = 0; i < 20; i++) vec[i] = 32'h5;
      run_frame(20, 0, lc);
      chk("s2_nwr", 64'(wq.size() - qb), 64'd2);
      chk_pair("s2_p0", 0, 2'd0, 32'h5, 4'd15);
      chk_pair("s2_p1", 1, 2'd1, 32'h5, 4'd5);
      chk("s2_pcnt", 64'(pair_cnt), 64'd2);

      // single word frame
      vec[0] = 32'hDEAD;
      run_frame(1, 0, lc);
      chk("s3_nwr", 64'(wq.size() - qb), 64'd1);
      chk_pair("s3_p0", 0, 2'd0, 32'hDEAD, 4'd1);
      if (wq.size() >= qb + 1) begin
         chk("s3_cyc",  64'(wq[qb].cyc), 64'(lc + 1));
         chk("s3_done", 64'(wq[qb].dn),  64'd1);
      end
      chk("s3_pcnt", 64'(pair_cnt), 64'd1);

      // first stream again with 3-cycle valid gaps
      vec[0] = A; vec[1] = A; vec[2] = A; vec[3] = B;
      run_frame(4, 3, lc);
      chk("s4_nwr", 64'(wq.size() - qb), 64'd2);
      chk_pair("s4_p0", 0, 2'd0, A, 4'd3);
      chk_pair("s4_p1", 1, 2'd1, B, 4'd1);
      chk("s4_pcnt", 64'(pair_cnt), 64'd2);

      // overflow: six distinct words into a 4-deep memory
      for (int i = 0; i < 6; i++) vec[i] = 32'(i + 1);
      run_frame(6, 0, lc);
      chk("s5_nwr", 64'(wq.size() - qb), 64'd4);
      for (int i = 0; i < 4; i++)
         chk_pair($sformatf("s5_p%0d", i), i, 2'(i), 32'(i + 1), 4'd1);
      chk("s5_ndone", 64'(done_cnt - db), 64'd1);
      chk("s5_ovf",   64'(overflow), 64'd1);
      chk("s5_pcnt",  64'(pair_cnt), 64'd4);
      chk("s5_ready", 64'(in_ready), 64'd0);

      // next start clears overflow and restarts at address 0
      db = done_cnt;
      qb = wq.size();
      start_frame();
      chk("s5b_ovf",  64'(overflow), 64'd0);
      chk("s5b_pcnt", 64'(pair_cnt), 64'd0);
      send(32'h77, 1'b1, c);
      wait_done();
      chk("s5b_nwr", 64'(wq.size() - qb), 64'd1);
      chk_pair("s5b_p0", 0, 2'd0, 32'h77, 4'd1);

      // async reset mid-run after A,A
      db = done_cnt;
      qb = wq.size();
      start_frame();
      send(A, 1'b0, c);
      send(A, 1'b0, c);
      #2 RST = 1'b0;
      #1 chk_idle_outputs("s6_rst");
      @(negedge CLK);
      chk("s6_nwr", 64'(wq.size() - qb), 64'd0);
      RST = 1'b1;
      @(negedge CLK);
      vec[0] = A; vec[1] = B;
      run_frame(2, 0, lc);
      chk("s6_post_nwr", 64'(wq.size() - qb), 64'd2);
      chk_pair("s6_p0", 0, 2'd0, A, 4'd1);
      chk_pair("s6_p1", 1, 2'd1, B, 4'd1);
      chk("s6_pcnt", 64'(pair_cnt), 64'd2);

      chk("cs_follows_wren", 64'(cs_bad), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
